mmss_counter_up: RTL and testbench

MMSS_COUNTER_UP -- requirements
Module: mmss_counter_up

---
 rtl/timer_pkg.sv | 40 ++++
 rtl/mmss_counter_up_if.sv | 27 ++
 rtl/bcd_digit_up.sv | 49 ++++
 rtl/mmss_counter_up.sv | 135 +++++++++++++
 tb/tb_mmss_counter_up.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared timer definitions: BCD digit limits, digit field offsets inside the
// 16-bit {m_tens, m_ones, s_tens, s_ones} word, and the nibble clamp helpers.
package timer_pkg;

    localparam logic [3:0] S_ONES_MAX = 4'd9;
    localparam logic [3:0] S_TENS_MAX = 4'd5;
    localparam logic [3:0] M_ONES_MAX = 4'd9;
    localparam logic [3:0] M_TENS_MAX = 4'd9;

    localparam int S_ONES_LSB = 0;
    localparam int S_TENS_LSB = 4;
    localparam int M_ONES_LSB = 8;
    localparam int M_TENS_LSB = 12;

    // 99:59, the terminal count.
    localparam logic [15:0] COUNT_MAX = 16'h9959;

    // Non-decimal nibbles (A..F) are forced to 9.
    function automatic logic [3:0] clamp_nibble(input logic [3:0] n);
        logic [3:0] r;
        if (n > 4'd9) begin
            r = 4'd9;
        end else begin
            r = n;
        end
        return r;
    endfunction

    // Clamp every digit of a BCD mm:ss word.
    function automatic logic [15:0] clamp_word(input logic [15:0] w);
        logic [15:0] r;
        r = 16'h0000;
        r[S_ONES_LSB +: 4] = clamp_nibble(w[S_ONES_LSB +: 4]);
        r[S_TENS_LSB +: 4] = clamp_nibble(w[S_TENS_LSB +: 4]);
        r[M_ONES_LSB +: 4] = clamp_nibble(w[M_ONES_LSB +: 4]);
        r[M_TENS_LSB +: 4] = clamp_nibble(w[M_TENS_LSB +: 4]);
        return r;
    endfunction

endpackage

// File: rtl/mmss_counter_up_if.sv
// Control/data bundle of the mm:ss up-counter.
// Optional lap display hold is compiled in when MMSS_UP_LAP_EN is defined.
interface mmss_counter_up_if;

    logic        enable_n;
    logic        tick;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] count;
    logic        rco_L;
    logic        at_max;
`ifdef MMSS_UP_LAP_EN
    logic        lap;
    logic        lap_active;

    modport master (output enable_n, tick, load, load_val, lap,
                    input  count, rco_L, at_max, lap_active);
    modport slave  (input  enable_n, tick, load, load_val, lap,
                    output count, rco_L, at_max, lap_active);
`else
    modport master (output enable_n, tick, load, load_val,
                    input  count, rco_L, at_max);
    modport slave  (input  enable_n, tick, load, load_val,
                    output count, rco_L, at_max);
`endif

endinterface

// File: rtl/bcd_digit_up.sv
// One BCD up-counting digit. Wraps to 0 (raising carry_out) at MAX, and also
// at 9 so that a digit loaded above its normal limit (e.g. s_tens 6..9)
// keeps counting up to 9 before wrapping. Load has priority over carry_in.
module bcd_digit_up #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       carry_in,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] digit_o,
    output logic [3:0] digit_d_o,
    output logic       carry_out
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;
    logic       wrap_s;

    assign wrap_s    = (digit_q == MAX) | (digit_q >= 4'd9);
    assign carry_out = carry_in & wrap_s;
    assign digit_o   = digit_q;
    assign digit_d_o = digit_d;

    // Next digit value: reset, then load, then count on carry_in.
    always_comb begin
        digit_d = digit_q;
        if (!rst) begin
            digit_d = 4'd0;
        end else if (load) begin
            digit_d = load_val;
        end else if (carry_in) begin
            if (wrap_s) begin
                digit_d = 4'd0;
            end else begin
                digit_d = digit_q + 4'd1;
            end
        end else begin
            digit_d = digit_q;
        end
    end

    // Digit state register.
    always_ff @(posedge clk) begin
        digit_q <= digit_d;
    end

endmodule

// File: rtl/mmss_counter_up.sv
// mm:ss BCD up-counter 00:00..99:59 with load, enable and ripple-carry out.
// WRAP=1 wraps to 00:00 after 99:59; WRAP=0 saturates at 99:59.
// Define MMSS_UP_LAP_EN to add the lap (display freeze) feature.
module mmss_counter_up
    import timer_pkg::*;
#(
    parameter int WRAP = 1
) (
    input logic              clk,
    input logic              rst,
    mmss_counter_up_if.slave bus
);

    logic        step_s;
    logic        c_s_ones_s;
    logic        c_s_tens_s;
    logic        c_m_ones_s;
    logic        term_s;
    logic        sat_load_s;
    logic        digit_load_s;
    logic [15:0] digit_val_s;
    logic [15:0] run_q;
    logic [15:0] run_d;
    logic        at_max_q;

    // A load masks the step, so a tick coincident with load is lost.
    assign step_s = ~bus.enable_n & bus.tick & ~bus.load;

    // In saturating mode the terminal carry reloads 99:59 instead of wrapping.
    assign sat_load_s   = term_s & (WRAP == 0);
    assign digit_load_s = bus.load | sat_load_s;
    assign digit_val_s  = bus.load ? clamp_word(bus.load_val) : COUNT_MAX;

    bcd_digit_up #(.MAX(S_ONES_MAX)) u_s_ones (
        .clk       (clk),
        .rst       (rst),
        .carry_in  (step_s),
        .load      (digit_load_s),
        .load_val  (digit_val_s[S_ONES_LSB +: 4]),
        .digit_o   (run_q[S_ONES_LSB +: 4]),
        .digit_d_o (run_d[S_ONES_LSB +: 4]),
        .carry_out (c_s_ones_s)
    );

    bcd_digit_up #(.MAX(S_TENS_MAX)) u_s_tens (
        .clk       (clk),
        .rst       (rst),
        .carry_in  (c_s_ones_s),
        .load      (digit_load_s),
        .load_val  (digit_val_s[S_TENS_LSB +: 4]),
        .digit_o   (run_q[S_TENS_LSB +: 4]),
        .digit_d_o (run_d[S_TENS_LSB +: 4]),
        .carry_out (c_s_tens_s)
    );

    bcd_digit_up #(.MAX(M_ONES_MAX)) u_m_ones (
        .clk       (clk),
        .rst       (rst),
        .carry_in  (c_s_tens_s),
        .load      (digit_load_s),
        .load_val  (digit_val_s[M_ONES_LSB +: 4]),
        .digit_o   (run_q[M_ONES_LSB +: 4]),
        .digit_d_o (run_d[M_ONES_LSB +: 4]),
        .carry_out (c_m_ones_s)
    );

    bcd_digit_up #(.MAX(M_TENS_MAX)) u_m_tens (
        .clk       (clk),
        .rst       (rst),
        .carry_in  (c_m_ones_s),
        .load      (digit_load_s),
        .load_val  (digit_val_s[M_TENS_LSB +: 4]),
        .digit_o   (run_q[M_TENS_LSB +: 4]),
        .digit_d_o (run_d[M_TENS_LSB +: 4]),
        .carry_out (term_s)
    );

    // at_max tracks the running value so it lines up with the updated count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            at_max_q <= 1'b0;
        end else begin
            at_max_q <= (run_d == COUNT_MAX);
        end
    end

    assign bus.at_max = at_max_q;
    assign bus.rco_L  = ~(rst & (run_q == COUNT_MAX) & step_s);

`ifdef MMSS_UP_LAP_EN
    logic        lap_active_q;
    logic        lap_active_d;
    logic [15:0] count_q;
    logic [15:0] count_d;

    // Lap toggles the display hold; a load always releases it.
    always_comb begin
        lap_active_d = lap_active_q;
        if (bus.load) begin
            lap_active_d = 1'b0;
        end else if (bus.lap) begin
            lap_active_d = ~lap_active_q;
        end else begin
            lap_active_d = lap_active_q;
        end
    end

    // Displayed count freezes while the hold is active, else follows running.
    always_comb begin
        count_d = run_d;
        if (lap_active_d) begin
            count_d = count_q;
        end else begin
            count_d = run_d;
        end
    end

    // Display and lap-hold registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q      <= 16'h0000;
            lap_active_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            lap_active_q <= lap_active_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.lap_active = lap_active_q;
`else
    assign bus.count = run_q;
`endif

endmodule

// File: tb/tb_mmss_counter_up.sv
// Scoreboard bench for mmss_counter_up: one WRAP=1 and one WRAP=0 instance
// driven with identical directed vectors.
module tb_mmss_counter_up;

    logic clk;
    logic rst;

    mmss_counter_up_if bus_w ();
    mmss_counter_up_if bus_s ();

    mmss_counter_up #(.WRAP(1)) u_wrap (.clk(clk), .rst(rst), .bus(bus_w));
    mmss_counter_up #(.WRAP(0)) u_sat  (.clk(clk), .rst(rst), .bus(bus_s));

    typedef struct {
        string       name;
        logic        rw;
        logic        rs;
        logic [15:0] cw;
        logic [15:0] cs;
        logic        mw;
        logic        ms;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pushed = 0;
    int   n_done   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef MMSS_UP_LAP_EN
    initial begin
        bus_w.lap = 1'b0;
        bus_s.lap = 1'b0;
    end
`endif

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs on both DUTs and queue what each should show.
    task automatic cyc(input logic r, input logic en_n, input logic tk, input logic ld,
                       input logic [15:0] lv, input string nm,
                       input logic rw, input logic rs,
                       input logic [15:0] cw, input logic [15:0] cs,
                       input logic mw, input logic ms);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        bus_w.enable_n = en_n; bus_w.tick = tk; bus_w.load = ld; bus_w.load_val = lv;
        bus_s.enable_n = en_n; bus_s.tick = tk; bus_s.load = ld; bus_s.load_val = lv;
        e.name = nm; e.rw = rw; e.rs = rs; e.cw = cw; e.cs = cs; e.mw = mw; e.ms = ms;
        sb.push_back(e);
        n_pushed++;
    endtask

    // Monitor: rco_L mid-cycle, count/at_max just after the following edge.
    initial begin
        exp_t  e;
        logic  a_rw;
        logic  a_rs;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e    = sb.pop_front();
                a_rw = bus_w.rco_L;
                a_rs = bus_s.rco_L;
                @(posedge clk);
                #1;
                chk({e.name, ".w.rco_L"},  {15'd0, a_rw},         {15'd0, e.rw});
                chk({e.name, ".s.rco_L"},  {15'd0, a_rs},         {15'd0, e.rs});
                chk({e.name, ".w.count"},  bus_w.count,           e.cw);
                chk({e.name, ".s.count"},  bus_s.count,           e.cs);
                chk({e.name, ".w.at_max"}, {15'd0, bus_w.at_max}, {15'd0, e.mw});
                chk({e.name, ".s.at_max"}, {15'd0, bus_s.at_max}, {15'd0, e.ms});
                n_done++;
            end
        end
    end

    initial begin
        rst = 1'b0;
        bus_w.enable_n = 1'b1; bus_w.tick = 1'b0; bus_w.load = 1'b0; bus_w.load_val = 16'h0000;
        bus_s.enable_n = 1'b1; bus_s.tick = 1'b0; bus_s.load = 1'b0; bus_s.load_val = 16'h0000;

        //  rst   en_n  tick  load  load_val   name        rw    rs    cw        cs        mw    ms
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, "reset0",   1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, "reset_ld", 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        // load with coincident tick: tick lost
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h0058, "ld0058",   1'b1, 1'b1, 16'h0058, 16'h0058, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "s0059",    1'b1, 1'b1, 16'h0059, 16'h0059, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "s0100",    1'b1, 1'b1, 16'h0100, 16'h0100, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "s0101",    1'b1, 1'b1, 16'h0101, 16'h0101, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, "notick",   1'b1, 1'b1, 16'h0101, 16'h0101, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, "disabled", 1'b1, 1'b1, 16'h0101, 16'h0101, 1'b0, 1'b0);
        // seconds tens loaded above 5 count on to 9 before carrying
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h0075, "ld0075",   1'b1, 1'b1, 16'h0075, 16'h0075, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "s0076",    1'b1, 1'b1, 16'h0076, 16'h0076, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "s0077",    1'b1, 1'b1, 16'h0077, 16'h0077, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "s0078",    1'b1, 1'b1, 16'h0078, 16'h0078, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "s0079",    1'b1, 1'b1, 16'h0079, 16'h0079, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "s0080",    1'b1, 1'b1, 16'h0080, 16'h0080, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h0099, "ld0099",   1'b1, 1'b1, 16'h0099, 16'h0099, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "s0100b",   1'b1, 1'b1, 16'h0100, 16'h0100, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h0959, "ld0959",   1'b1, 1'b1, 16'h0959, 16'h0959, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "s1000",    1'b1, 1'b1, 16'h1000, 16'h1000, 1'b0, 1'b0);
        // nibble clamp: F,A,3,C -> 9,9,3,9
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'hFA3C, "ldFA3C",   1'b1, 1'b1, 16'h9939, 16'h9939, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "s9940",    1'b1, 1'b1, 16'h9940, 16'h9940, 1'b0, 1'b0);
        // terminal count: wrap vs saturate
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h9959, "ld9959",   1'b1, 1'b1, 16'h9959, 16'h9959, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "term1",    1'b0, 1'b0, 16'h0000, 16'h9959, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "term2",    1'b1, 1'b0, 16'h0001, 16'h9959, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "term3",    1'b1, 1'b0, 16'h0002, 16'h9959, 1'b0, 1'b1);
        // load at terminal count suppresses rco_L
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h9959, "ld9959t",  1'b1, 1'b1, 16'h9959, 16'h9959, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, "maxdis",   1'b1, 1'b1, 16'h9959, 16'h9959, 1'b1, 1'b1);
        // reset at 99:59 with a step pending
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, "rstmax",   1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        // reset mid-count overrides a coincident load and tick
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h1233, "ld1233",   1'b1, 1'b1, 16'h1233, 16'h1233, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "s1234",    1'b1, 1'b1, 16'h1234, 16'h1234, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h5555, "rstld",    1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "s0001",    1'b1, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, "idle",     1'b1, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);

        for (int i = 0; i < 20 && n_done != n_pushed; i++) begin
            @(posedge clk);
        end
        #3;
        if (n_done != n_pushed) begin
            n_checks++;
            $display("FAIL drain: got %0d responses expected %0d", n_done, n_pushed);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
